regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised multi-port integer register file for the pipelined core, generalising the single-write, dual-read file.
- Configurable register count, data width, read-port count and write-port count.
- Hardwired-zero register x0, deterministic write-conflict priority and a per-register busy scoreboard for issue-stage hazard detection.
- Sits between decode (read ports, issue) and writeback (write ports).

Parameters:
- XLEN, 32, data width of each register.
- NUM_REGS, 32, number of architectural registers; power of two, at least 2.
- NUM_READ, 2, number of read ports.
- NUM_WRITE, 1, number of write ports.
- Derived localparam AW = $clog2(NUM_REGS), the register address width.

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous and active-high; clears all registers, busy bits and busy_cnt.
- rd_addr  input  NUM_READ*AW  packed read addresses; port i uses bits [i*AW +: AW].
- rd_data  output  NUM_READ*XLEN  packed read data, combinational.
- rd_busy  output  NUM_READ  busy flag of each addressed register, combinational.
- wr_en  input  NUM_WRITE  per-port write enable.
- wr_addr  input  NUM_WRITE*AW  packed write addresses.
- wr_data  input  NUM_WRITE*XLEN  packed write data.
- iss_en  input  1  issue strobe; marks iss_rd busy.
- iss_rd  input  AW  destination register of the issuing instruction.
- flush  input  1  clears every busy bit (pipeline flush).
- busy_cnt  output  AW+1  registered count of busy registers.

Behaviour:
- Reset (asynchronous, rst=1):
  - All registers are set to 0 and all busy bits to 0.
  - busy_cnt is 0.
  - rd_data reads 0 and rd_busy reads 0 for every address while in reset.
- Register x0:
  - Always reads 0 and is never busy.
  - Writes and issues to address 0 are ignored and leave busy_cnt unchanged.
- Reads:
  - Combinational, zero latency.
  - Without bypass, a value written at edge N is visible on rd_data after edge N.
- Writes:
  - A write on port j occurs at the rising edge when wr_en[j]=1.
  - If several ports write the same address in one cycle, the highest-indexed port wins.
  - Writes to different addresses in the same cycle all commit.
- Scoreboard, next state of busy[r] for r != 0, in priority order:
  1. flush=1: 0.
  2. iss_en=1 and iss_rd==r: 1. The new producer wins over a same-cycle writeback.
  3. Any wr_en[j]=1 with wr_addr[j]==r: 0.
  4. Otherwise: unchanged.
- Writes commit data regardless of busy state; the scoreboard never blocks a write.
- busy_cnt:
  - Registered, and always equal to the popcount of the busy vector after each edge.
  - Implemented as the popcount of the next-state busy vector, so it can never drift from the busy bits.
  - Maximum value is NUM_REGS-1.
- flush with iss_en in the same cycle: flush wins; all busy bits are 0 and busy_cnt is 0 after the edge.
- Out-of-range addresses cannot occur, because NUM_REGS is a power of two.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- When defined: write-to-read forwarding.
  - If any wr_en[j]=1 with wr_addr[j]==rd_addr[i] != 0, rd_data[i] returns the winning wr_data (highest j) in the same cycle.
  - rd_busy[i] reports the post-write busy value, i.e. 0 unless the same register is also being issued in that cycle.
- When undefined: rd_data and rd_busy reflect stored state only, so a same-cycle write becomes visible one cycle later.

Test Plan:
- Reset and x0: assert rst mid-run after writing x5=0xDEADBEEF -> all rd_data=0, busy_cnt=0 immediately, without waiting for a clock edge. Then write x0=0x1234 -> reading x0 returns 0.
- Basic read/write, NUM_READ=2: write x3=0xA5A5A5A5 at edge N; read ports 0 and 1 both at x3 -> both return 0xA5A5A5A5 after edge N. Without bypass, the value before edge N is 0.
- Write conflict, NUM_WRITE=2: port0 writes x7=0x11 and port1 writes x7=0x22 in the same cycle -> x7 reads 0x22.
- Scoreboard: issue x4 -> rd_busy=1, busy_cnt=1. In one cycle, issue x4 again while writeback x4 -> busy stays 1. Next cycle, writeback x4 -> busy 0, busy_cnt 0.
- Flush: issue x1, x2, x3 on consecutive cycles (busy_cnt=3). Assert flush together with iss_en on x9 -> busy_cnt=0 and x9 is not busy.
- Bypass (REGFILE_BYPASS_EN): write x6=0xCAFEF00D while reading x6 in the same cycle -> rd_data=0xCAFEF00D combinationally. With the macro undefined, the same stimulus returns the old value 0.

Source files
------------

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port integer register file with hardwired-zero
// x0, highest-port-wins write priority and a per-register busy scoreboard used
// by the issue stage for hazard detection.
//
// Ports:
//   CLK       clock, all state changes on the rising edge
//   rst       asynchronous active-high reset (registers, busy bits, busy_cnt)
//   rd_addr   packed read addresses, port i at [i*AW +: AW]
//   rd_data   packed read data, combinational
//   rd_busy   busy flag of each addressed register, combinational
//   wr_en     per-port write enable
//   wr_addr   packed write addresses
//   wr_data   packed write data
//   iss_en    issue strobe, marks iss_rd busy
//   iss_rd    destination register of the issuing instruction
//   flush     clears every busy bit
//   busy_cnt  registered popcount of the busy vector
//
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write data
// (and the post-write busy value) onto matching read ports.
// NUM_REGS must be a power of two and at least 2.

module regfile_mp #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned NUM_REGS  = 32,
  parameter int unsigned NUM_READ  = 2,
  parameter int unsigned NUM_WRITE = 1,
  localparam int unsigned AW       = $clog2(NUM_REGS)
) (
  input  logic                      CLK,
  input  logic                      rst,
  input  logic [NUM_READ*AW-1:0]    rd_addr,
  output logic [NUM_READ*XLEN-1:0]  rd_data,
  output logic [NUM_READ-1:0]       rd_busy,
  input  logic [NUM_WRITE-1:0]      wr_en,
  input  logic [NUM_WRITE*AW-1:0]   wr_addr,
  input  logic [NUM_WRITE*XLEN-1:0] wr_data,
  input  logic                      iss_en,
  input  logic [AW-1:0]             iss_rd,
  input  logic                      flush,
  output logic [AW:0]               busy_cnt
);

  localparam int unsigned CW = AW + 1;

  // Architectural state
  logic [XLEN-1:0]     regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy;

  // Per-register write decode: hit flag and winning (highest port) data
  logic [NUM_REGS-1:0] wr_hit;
  logic [XLEN-1:0]     wr_win [NUM_REGS];

  // Next-state scoreboard
  logic [NUM_REGS-1:0] next_busy;

  // Unpacked read addresses
  logic [AW-1:0]       rd_a [NUM_READ];

  // Population count of a busy vector
  function automatic logic [CW-1:0] popcount(input logic [NUM_REGS-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int unsigned k = 0; k < NUM_REGS; k++) begin
      c = c + CW'(v[k]);
    end
    return c;
  endfunction

  // Write decode; ascending port loop so the highest-indexed port overrides
  always_comb begin
    wr_hit = '0;
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      wr_win[r] = '0;
    end
    for (int unsigned r = 1; r < NUM_REGS; r++) begin
      for (int unsigned j = 0; j < NUM_WRITE; j++) begin
        if (wr_en[j] && (wr_addr[j*AW +: AW] == AW'(r))) begin
          wr_hit[r] = 1'b1;
          wr_win[r] = wr_data[j*XLEN +: XLEN];
        end
      end
    end
  end

  // Scoreboard next state: flush > issue > writeback > hold; x0 never busy
  always_comb begin
    next_busy = busy;
    for (int unsigned r = 1; r < NUM_REGS; r++) begin
      if (flush) begin
        next_busy[r] = 1'b0;
      end else if (iss_en && (iss_rd == AW'(r))) begin
        next_busy[r] = 1'b1;
      end else if (wr_hit[r]) begin
        next_busy[r] = 1'b0;
      end
    end
    next_busy[0] = 1'b0;
  end

  // Register array; x0 is never hit by the decode so it stays zero
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        regs[r] <= '0;
      end
    end else begin
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        if (wr_hit[r]) begin
          regs[r] <= wr_win[r];
        end
      end
    end
  end

  // Busy bits and count; count derives from next_busy so it cannot drift
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= next_busy;
      busy_cnt <= popcount(next_busy);
    end
  end

  // Split packed read addresses
  always_comb begin
    for (int unsigned i = 0; i < NUM_READ; i++) begin
      rd_a[i] = rd_addr[i*AW +: AW];
    end
  end

  // Read ports; forced to zero in reset and for x0
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int unsigned i = 0; i < NUM_READ; i++) begin
      if (!rst && (rd_a[i] != '0)) begin
`ifdef REGFILE_BYPASS_EN
        if (wr_hit[rd_a[i]]) begin
          rd_data[i*XLEN +: XLEN] = wr_win[rd_a[i]];
          rd_busy[i]              = next_busy[rd_a[i]];
        end else begin
          rd_data[i*XLEN +: XLEN] = regs[rd_a[i]];
          rd_busy[i]              = busy[rd_a[i]];
        end
`else
        rd_data[i*XLEN +: XLEN] = regs[rd_a[i]];
        rd_busy[i]              = busy[rd_a[i]];
`endif
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: self-checking bench for regfile_mp (XLEN=32, 32 registers,
// 2 read ports, 2 write ports). Table-driven single-cycle vectors followed by
// hand-written sequences for bypass, scoreboard and asynchronous reset.

module tb_regfile_mp;

  localparam int unsigned XLEN = 32;
  localparam int unsigned NR   = 32;
  localparam int unsigned NRD  = 2;
  localparam int unsigned NWR  = 2;
  localparam int unsigned AW   = 5;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                CLK;
  logic                rst;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic                iss_en;
  logic [AW-1:0]       iss_rd;
  logic                flush;
  logic [AW:0]         busy_cnt;

  int errors = 0;
  int checks = 0;

  regfile_mp #(
    .XLEN(XLEN), .NUM_REGS(NR), .NUM_READ(NRD), .NUM_WRITE(NWR)
  ) dut (
    .CLK(CLK), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_busy(rd_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_rd(iss_rd), .flush(flush), .busy_cnt(busy_cnt)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic        ie;
    logic [4:0]  ir;
    logic        fl;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] ed0;
    logic [31:0] ed1;
    logic        eb0;
    logic        eb1;
    logic [5:0]  ecnt;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle();
    wr_en  = '0;
    iss_en = 1'b0;
    flush  = 1'b0;
  endtask

  task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
    rd_addr = {a1, a0};
  endtask

  // Advance one edge, sample shortly after it, then drop strobes
  task automatic step();
    @(posedge CLK);
    #1;
    idle();
    #1;
  endtask

  task automatic check_reads(input string tag, input logic [31:0] d0, input logic [31:0] d1,
                             input logic b0, input logic b1, input logic [5:0] cnt);
    check({tag, "_d0"}, rd_data[31:0], d0);
    check({tag, "_d1"}, rd_data[63:32], d1);
    check({tag, "_b0"}, 32'(rd_busy[0]), 32'(b0));
    check({tag, "_b1"}, 32'(rd_busy[1]), 32'(b1));
    check({tag, "_cnt"}, 32'(busy_cnt), 32'(cnt));
  endtask

  initial begin
    // we, wa0, wd0, wa1, wd1, ie, ir, fl, ra0, ra1, ed0, ed1, eb0, eb1, ecnt
    vecs[0]  = '{2'b01, 5'd3, 32'hA5A5A5A5, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd3, 5'd3,
                 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0, 1'b0, 6'd0};
    vecs[1]  = '{2'b11, 5'd7, 32'h11, 5'd7, 32'h22, 1'b0, 5'd0, 1'b0, 5'd7, 5'd3,
                 32'h22, 32'hA5A5A5A5, 1'b0, 1'b0, 6'd0};
    vecs[2]  = '{2'b11, 5'd8, 32'h1, 5'd9, 32'h2, 1'b0, 5'd0, 1'b0, 5'd8, 5'd9,
                 32'h1, 32'h2, 1'b0, 1'b0, 6'd0};
    vecs[3]  = '{2'b01, 5'd0, 32'h1234, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd3,
                 32'h0, 32'hA5A5A5A5, 1'b0, 1'b0, 6'd0};
    vecs[4]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd4, 1'b0, 5'd4, 5'd0,
                 32'h0, 32'h0, 1'b1, 1'b0, 6'd1};
    vecs[5]  = '{2'b01, 5'd4, 32'h44, 5'd0, 32'h0, 1'b1, 5'd4, 1'b0, 5'd4, 5'd0,
                 32'h44, 32'h0, 1'b1, 1'b0, 6'd1};
    vecs[6]  = '{2'b10, 5'd0, 32'h0, 5'd4, 32'h55, 1'b0, 5'd0, 1'b0, 5'd4, 5'd7,
                 32'h55, 32'h22, 1'b0, 1'b0, 6'd0};
    vecs[7]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd1, 1'b0, 5'd1, 5'd2,
                 32'h0, 32'h0, 1'b1, 1'b0, 6'd1};
    vecs[8]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd2, 1'b0, 5'd2, 5'd1,
                 32'h0, 32'h0, 1'b1, 1'b1, 6'd2};
    vecs[9]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b0, 5'd3, 5'd1,
                 32'hA5A5A5A5, 32'h0, 1'b1, 1'b1, 6'd3};
    vecs[10] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b1, 5'd9, 5'd3,
                 32'h2, 32'hA5A5A5A5, 1'b0, 1'b0, 6'd0};
    vecs[11] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b0, 5'd0, 5'd9,
                 32'h0, 32'h2, 1'b0, 1'b0, 6'd0};

    // Power-on reset
    rst = 1'b1;
    idle();
    iss_rd  = '0;
    wr_addr = '0;
    wr_data = '0;
    set_rd(5'd3, 5'd7);
    #2;
    check_reads("por", 32'h0, 32'h0, 1'b0, 1'b0, 6'd0);
    @(posedge CLK);
    #1;
    rst = 1'b0;
    #1;

    // Table-driven single-cycle vectors
    for (int k = 0; k < 12; k++) begin
      wr_en   = vecs[k].we;
      wr_addr = {vecs[k].wa1, vecs[k].wa0};
      wr_data = {vecs[k].wd1, vecs[k].wd0};
      iss_en  = vecs[k].ie;
      iss_rd  = vecs[k].ir;
      flush   = vecs[k].fl;
      set_rd(vecs[k].ra0, vecs[k].ra1);
      step();
      check_reads($sformatf("v%0d", k), vecs[k].ed0, vecs[k].ed1,
                  vecs[k].eb0, vecs[k].eb1, vecs[k].ecnt);
    end

    // Same-cycle write/read visibility on x12
    wr_en   = 2'b01;
    wr_addr = {5'd0, 5'd12};
    wr_data = {32'h0, 32'h600D};
    set_rd(5'd12, 5'd12);
    #1;
    check("pre_edge_x12", rd_data[31:0], BYP ? 32'h600D : 32'h0);
    step();
    check("post_edge_x12", rd_data[63:32], 32'h600D);

    // Bypass on a busy register: x6 issued, then written while read
    iss_en = 1'b1;
    iss_rd = 5'd6;
    step();
    check("x6_iss_cnt", 32'(busy_cnt), 32'd1);
    wr_en   = 2'b01;
    wr_addr = {5'd0, 5'd6};
    wr_data = {32'h0, 32'hCAFEF00D};
    set_rd(5'd6, 5'd6);
    #1;
    check("byp_x6_data", rd_data[31:0], BYP ? 32'hCAFEF00D : 32'h0);
    check("byp_x6_busy", 32'(rd_busy[1]), BYP ? 32'd0 : 32'd1);
    step();
    check_reads("x6_after", 32'hCAFEF00D, 32'hCAFEF00D, 1'b0, 1'b0, 6'd0);

    // Same-cycle issue and write of x13: producer keeps it busy
    wr_en   = 2'b10;
    wr_addr = {5'd13, 5'd0};
    wr_data = {32'h77, 32'h0};
    iss_en  = 1'b1;
    iss_rd  = 5'd13;
    set_rd(5'd13, 5'd0);
    #1;
    check("byp_x13_data", rd_data[31:0], BYP ? 32'h77 : 32'h0);
    check("byp_x13_busy", 32'(rd_busy[0]), BYP ? 32'd1 : 32'd0);
    step();
    check_reads("x13_after", 32'h77, 32'h0, 1'b1, 1'b0, 6'd1);
    flush = 1'b1;
    step();
    check("flush_cnt", 32'(busy_cnt), 32'd0);

    // Asynchronous reset mid-run with live state
    wr_en   = 2'b01;
    wr_addr = {5'd0, 5'd5};
    wr_data = {32'h0, 32'hDEADBEEF};
    set_rd(5'd5, 5'd11);
    step();
    check("x5_written", rd_data[31:0], 32'hDEADBEEF);
    iss_en = 1'b1;
    iss_rd = 5'd11;
    step();
    check_reads("pre_rst", 32'hDEADBEEF, 32'h0, 1'b0, 1'b1, 6'd1);
    rst = 1'b1;
    #1;
    check_reads("in_rst", 32'h0, 32'h0, 1'b0, 1'b0, 6'd0);
    @(posedge CLK);
    #1;
    rst = 1'b0;
    wr_en   = 2'b01;
    wr_addr = {5'd0, 5'd0};
    wr_data = {32'h0, 32'h1234};
    step();
    set_rd(5'd0, 5'd5);
    #1;
    check_reads("post_rst", 32'h0, 32'h0, 1'b0, 1'b0, 6'd0);
    set_rd(5'd3, 5'd7);
    #1;
    check("post_rst_x3", rd_data[31:0], 32'h0);
    check("post_rst_x7", rd_data[63:32], 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
